// File: rtl/i2c_pkg.sv
// Shared types and constants for the 16-bit write-only I2C responder.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    DATA_HI,
    ACK_H,
    DATA_LO,
    ACK_L,
    WAIT_STOP
  } state_t;

  localparam logic       ACK       = 1'b0;
  localparam logic [3:0] BYTE_BITS = 4'd8;

  // State that follows each ACK slot once the 9th SCL clock has ended.
  function automatic state_t ack_next(input state_t s);
    case (s)
      ACK_A:   return DATA_HI;
      ACK_H:   return DATA_LO;
      default: return WAIT_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2c_edge_sync.sv
// Two-flop synchronizer plus a history flop; reports level and single-clk edges.
module i2c_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  // Flops reset high so an idle bus produces no edge when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], pin};
  end

  assign lvl  = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2c_slave_16wrt.sv
// Write-only I2C responder: address byte, then a 16-bit command (high byte first),
// presented on data16 with a one-clk vld strobe when the low byte completes.
module i2c_slave_16wrt
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [15:0] data16,
  output logic        vld,
  output logic        busy
);

  // state     | meaning
  // IDLE      | bus free, waiting for START
  // ADDR      | shifting in the address byte
  // ACK_A     | acknowledging our address
  // DATA_HI   | shifting in the command high byte
  // ACK_H     | acknowledging the high byte
  // DATA_LO   | shifting in the command low byte
  // ACK_L     | acknowledging the low byte (data16/vld already updated)
  // WAIT_STOP | frame done or not ours; SDA left released until STOP/START

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  hi_q;
  logic [15:0] data16_q;
  logic        vld_q;
  logic        drv_q;

  logic       start_c, stop_c, last_bit;
  logic [7:0] byte_nxt;

  i2c_edge_sync u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (SCL),
    .lvl  (scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_edge_sync u_sda_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (SDA),
    .lvl  (sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign start_c  = scl_lvl & sda_fall;
  assign stop_c   = scl_lvl & sda_rise;
  assign byte_nxt = {shift_q[6:0], sda_lvl};
  assign last_bit = (cnt_q == BYTE_BITS - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shift_q  <= 8'h00;
      hi_q     <= 8'h00;
      data16_q <= 16'h0000;
      vld_q    <= 1'b0;
      drv_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (stop_c) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        drv_q   <= 1'b0;
      end else if (start_c) begin
        state_q <= ADDR;
        cnt_q   <= 4'd0;
        drv_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR, DATA_HI, DATA_LO: begin
            if (scl_rise) begin
              shift_q <= byte_nxt;
              cnt_q   <= last_bit ? 4'd0 : cnt_q + 4'd1;
              if (last_bit) begin
                if (state_q == ADDR) begin
                  state_q <= (byte_nxt == {DEV_ADDR, 1'b0}) ? ACK_A : WAIT_STOP;
                end else if (state_q == DATA_HI) begin
                  hi_q    <= byte_nxt;
                  state_q <= ACK_H;
                end else begin
                  data16_q <= {hi_q, byte_nxt};
                  vld_q    <= 1'b1;
                  state_q  <= ACK_L;
                end
              end
            end
          end
          // First falling edge ends bit 8 and starts the drive; the next ends the ACK clock.
          ACK_A, ACK_H, ACK_L: begin
            if (scl_fall) begin
              if (!drv_q) begin
                drv_q <= 1'b1;
              end else begin
                drv_q   <= 1'b0;
                state_q <= ack_next(state_q);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDA    = drv_q ? ACK : 1'bz;
  assign data16 = data16_q;
  assign vld    = vld_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_16wrt.sv
// Bench for i2c_slave_16wrt: bit-banged I2C master, vld/data16 scoreboard.
module tb_i2c_slave_16wrt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_low = 1'b0;
  wire         sda_bus;
  logic [15:0] data16;
  logic        vld;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          n_push = 0;
  int          n_vld = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_d16 = 16'h0000;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_16wrt #(.DEV_ADDR(7'h1A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SCL   (scl_m),
    .SDA   (sda_bus),
    .data16(data16),
    .vld   (vld),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every vld must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n && vld) begin
      n_vld++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL vld_unexpected: got data16=%h expected no vld", data16);
      end else begin
        check_w("vld_data16", data16, sb_q.pop_front());
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period of 16 clk: SDA set mid-low, sampled mid-high.
  task automatic bit_tx(input logic b, output logic rd);
    clks(4); sda_low = !b;
    clks(4); scl_m = 1'b1;
    clks(4); rd = sda_bus;
    clks(4); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_tx(d[i], r);
    bit_tx(1'b1, ack);
  endtask

  task automatic do_start;
    if (!scl_m) begin
      clks(4); sda_low = 1'b0;
      clks(4); scl_m = 1'b1;
      clks(4);
    end
    sda_low = 1'b1;
    clks(4); scl_m = 1'b0;
  endtask

  task automatic do_stop;
    clks(4); sda_low = 1'b1;
    clks(4); scl_m = 1'b1;
    clks(4); sda_low = 1'b0;
    clks(8);
  endtask

  task automatic expect_word(input logic [15:0] w);
    sb_q.push_back(w);
    exp_d16 = w;
    n_push++;
  endtask

  // Full 3-byte frame; good=1 means address 34 so every byte must be ACKed.
  task automatic frame(input logic [7:0] a, input logic [15:0] w, input logic good);
    logic ack;
    logic e;
    e = !good;
    if (good) expect_word(w);
    do_start;
    check_b("busy_after_start", busy, 1'b1);
    send_byte(a, ack);        check_b("ack_addr", ack, e);
    send_byte(w[15:8], ack);  check_b("ack_hi", ack, e);
    send_byte(w[7:0], ack);   check_b("ack_lo", ack, e);
    do_stop;
    check_b("busy_after_stop", busy, 1'b0);
    check_w("data16_after_frame", data16, exp_d16);
  endtask

  initial begin
    logic        ack;
    logic        r;
    logic [7:0]  d;
    logic [15:0] cmds[7];
    cmds = '{16'h0105, 16'h0305, 16'h0812, 16'h0A06, 16'h0C62, 16'h0E01, 16'h1201};

    clks(3);
    check_w("rst_data16", data16, 16'h0000);
    check_b("rst_vld", vld, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_sda", sda_bus, 1'b1);
    rst_n = 1'b1;
    clks(4);

    frame(8'h34, 16'h0105, 1'b1);
    frame(8'h36, 16'h0305, 1'b0);

    // Read request: NACKed, block parks in WAIT_STOP until the STOP.
    do_start;
    send_byte(8'h35, ack);
    check_b("ack_read_req", ack, 1'b1);
    check_b("busy_wait_stop", busy, 1'b1);
    do_stop;
    check_b("busy_after_read", busy, 1'b0);
    check_w("data16_after_read", data16, exp_d16);

    // STOP after the high byte only: no word delivered.
    do_start;
    send_byte(8'h34, ack); check_b("ack_addr_short", ack, 1'b0);
    send_byte(8'h0C, ack); check_b("ack_hi_short", ack, 1'b0);
    do_stop;
    check_b("busy_after_short", busy, 1'b0);
    check_w("data16_after_short", data16, exp_d16);
    frame(8'h34, 16'h0E01, 1'b1);

    // Repeated START after 4 data bits, then a good frame.
    expect_word(16'h1201);
    do_start;
    send_byte(8'h34, ack); check_b("ack_addr_rs", ack, 1'b0);
    d = 8'hA5;
    for (int i = 7; i >= 4; i--) bit_tx(d[i], r);
    do_start;
    check_b("busy_rs", busy, 1'b1);
    send_byte(8'h34, ack); check_b("ack_addr_rs2", ack, 1'b0);
    send_byte(8'h12, ack); check_b("ack_hi_rs2", ack, 1'b0);
    send_byte(8'h01, ack); check_b("ack_lo_rs2", ack, 1'b0);
    do_stop;
    check_w("data16_rs", data16, 16'h1201);

    for (int k = 0; k < 7; k++) frame(8'h34, cmds[k], 1'b1);

    // Replay the sequence; reset lands while the 4th frame's high byte is being ACKed.
    for (int k = 0; k < 3; k++) frame(8'h34, cmds[k], 1'b1);
    do_start;
    send_byte(8'h34, ack); check_b("ack_addr_f4", ack, 1'b0);
    d = cmds[3][15:8];
    for (int i = 7; i >= 0; i--) bit_tx(d[i], r);
    clks(4); sda_low = 1'b0;
    clks(4); scl_m = 1'b1;
    clks(4);
    check_b("ack_driven_before_rst", sda_bus, 1'b0);
    rst_n = 1'b0;
    #1;
    check_b("sda_released_by_rst", sda_bus, 1'b1);
    check_w("data16_by_rst", data16, 16'h0000);
    check_b("vld_by_rst", vld, 1'b0);
    check_b("busy_by_rst", busy, 1'b0);
    exp_d16 = 16'h0000;
    @(negedge clk);
    clks(2);
    rst_n = 1'b1;
    clks(2);
    scl_m = 1'b0;
    do_stop;
    check_b("busy_after_rst_stop", busy, 1'b0);
    check_w("data16_after_rst_stop", data16, 16'h0000);
    frame(8'h34, cmds[5], 1'b1);

    clks(20);
    check_w("sb_empty", 16'(sb_q.size()), 16'd0);
    check_w("vld_count", 16'(n_vld), 16'(n_push));
    check_w("vld_count_abs", 16'(n_vld), 16'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
